// File: rtl/as_event_logger_if.sv
// rtl/as_event_logger_if.sv - record drain handshake between as_event_logger and its consumer
interface as_event_logger_if #(
    parameter int W = 19
);
    logic         rd_valid;
    logic         rd_ready;
    logic [W-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/as_event_logger.sv
// rtl/as_event_logger.sv - timestamps level changes on {m,p,b,a} into a show-ahead record FIFO (TS_SAT_EN: saturating timestamp)
module as_event_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic [3:0]                 ev_in,
    as_event_logger_if.master          rd,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       drop
);
    localparam int REC_W = TS_W + 3;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Event detection and per-channel pending slots
    logic [TS_W-1:0]  ts;
    logic [3:0]       ev_q;
    logic [3:0]       chg;
    logic [3:0]       pending;
    logic [3:0]       lvl_p;
    logic [TS_W-1:0]  ts_p [4];

    // Drain selection
    logic [1:0]       sel;
    logic [3:0]       drain;
    logic [REC_W-1:0] rec_in;

    // FIFO storage
    logic [REC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             empty;
    logic             push;
    logic             pop;

    assign chg   = ev_in ^ ev_q;
    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_W'(DEPTH));
    assign count = cnt;

    assign pop   = !empty && rd.rd_ready;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign push  = (|pending) && (!full || pop);

    assign rd.rd_valid = !empty;
    assign rd.rd_data  = empty ? '0 : mem[rd_ptr];

    // Lowest-index pending channel is drained first
    always_comb begin
        sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending[i]) sel = 2'(i);
        end
    end

    // One-hot of the channel whose slot is emptied into the FIFO this cycle
    always_comb begin
        drain  = push ? 4'(4'b0001 << sel) : 4'b0000;
        rec_in = {sel, lvl_p[sel], ts_p[sel]};
    end

    // Free-running timestamp; clr restarts it from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts <= '0;
        end else if (clr) begin
            ts <= '0;
`ifdef TS_SAT_EN
        end else if (ts != '1) begin
            ts <= ts + TS_W'(1);
`else
        end else begin
            ts <= ts + TS_W'(1);
`endif
        end
    end

    // Capture changes into pending slots; a capture on the slot being drained wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_q    <= '0;
            pending <= '0;
            lvl_p   <= '0;
            drop    <= 1'b0;
            for (int i = 0; i < 4; i++) ts_p[i] <= '0;
        end else if (clr) begin
            // Follow the lines so the clear itself is not seen as a change.
            ev_q    <= ev_in;
            pending <= '0;
            drop    <= 1'b0;
        end else begin
            ev_q <= ev_in;
            for (int i = 0; i < 4; i++) begin
                if (chg[i]) begin
                    pending[i] <= 1'b1;
                    lvl_p[i]   <= ev_in[i];
                    ts_p[i]    <= ts;
                    if (pending[i] && !drain[i]) drop <= 1'b1;
                end else if (drain[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Record storage; contents are only visible while rd_valid is high
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= rec_in;
    end
endmodule
